// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the rv32i instruction-fetch stage.
//   ADDR_WIDTH / DATA_WIDTH  : PC and instruction widths
//   RESET_PC_DEFAULT         : default boot PC
//   FETCH_DEPTH_DEFAULT      : default buffer depth / maximum requests in flight
//   fetch_state_t            : fetch control states
//   fetch_entry_t            : {pc, instr} pair held in the fetch FIFOs
//   next_word_pc()           : sequential word PC, wrapping at 2^32
package fetch_stage_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_DEFAULT    = 32'h0000_0000;
  localparam int                    FETCH_DEPTH_DEFAULT = 2;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_RUN,
    FETCH_FLUSH
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_WIDTH-1:0] next_word_pc(input logic [ADDR_WIDTH-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t used by the fetch stage.
//   clk, rst    : clock, asynchronous active-high reset (pointers only)
//   push, entry : write entry when push (ignored when full and not popping)
//   pop         : drop the head entry (ignored when empty)
//   flush       : discard all entries; wins over push and pop
//   head        : oldest entry (contents undefined when empty)
//   count       : number of stored entries
//   full, empty : occupancy flags
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  entry,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // A full FIFO can still take a push in the same cycle its head leaves.
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !flush && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= entry;
  end

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && full && !pop));

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the rv32i core.
// Issues sequential word fetches to instruction memory while credits allow,
// pairs in-order responses with their PCs and buffers them for decode.
// A redirect flushes the buffer, retargets the PC and marks every request
// still in flight as stale so its response is discarded on arrival.
//   clk, rst         : clock, asynchronous active-high reset
//   imem_req_*       : fetch request (valid/ready), word-aligned address
//   imem_resp_*      : in-order instruction return, never back-pressured
//   redirect_*       : branch/jump redirect from execute
//   if_valid/ready   : handshake toward decode
//   if_instr, if_pc  : buffered instruction and its PC
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int                    FETCH_DEPTH = FETCH_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc
);

  localparam int CW = $clog2(FETCH_DEPTH + 1);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         drop_cnt;
  logic [CW-1:0]         drop_nxt;

  logic                  accept;
  logic                  keep_resp;
  logic                  credit_free;

  fetch_entry_t          buf_in;
  fetch_entry_t          buf_head;
  logic [CW-1:0]         buf_count;
  logic                  buf_full;
  logic                  buf_empty;
  logic                  buf_pop;

  fetch_entry_t          pcq_in;
  fetch_entry_t          pcq_head;
  logic [CW-1:0]         pcq_count;
  logic                  pcq_full;
  logic                  pcq_empty;

  logic                  unused_bits;

  // Stale responses still occupy a credit, so the buffer always has room
  // for every response that will be kept.
  assign credit_free    = ({1'b0, outstanding} + {1'b0, buf_count}) < (CW + 1)'(FETCH_DEPTH);
  assign imem_req_valid = (state != FETCH_IDLE) && !redirect_valid && credit_free;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  // A response arriving with a redirect belongs to the abandoned path.
  assign keep_resp = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;
  assign buf_pop   = if_valid && if_ready && !redirect_valid;
  assign buf_in    = {pcq_head.pc, imem_resp_data};
  assign pcq_in    = {pc_q, {DATA_WIDTH{1'b0}}};

  assign if_valid = !buf_empty;
  assign if_instr = buf_empty ? '0 : buf_head.instr;
  assign if_pc    = buf_empty ? '0 : buf_head.pc;

  always_comb begin
    drop_nxt = drop_cnt;
    if (redirect_valid)
      drop_nxt = imem_resp_valid ? (outstanding - CW'(1)) : outstanding;
    else if (imem_resp_valid && (drop_cnt != '0))
      drop_nxt = drop_cnt - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH_IDLE;
      pc_q        <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      case ({accept, imem_resp_valid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      if (redirect_valid)
        pc_q <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      else if (accept)
        pc_q <= next_word_pc(pc_q);

      drop_cnt <= drop_nxt;

      // FLUSH lasts exactly as long as stale responses remain in flight.
      case (state)
        FETCH_IDLE: state <= FETCH_RUN;
        default:    state <= (drop_nxt != '0) ? FETCH_FLUSH : FETCH_RUN;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(FETCH_DEPTH)) u_entry_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (keep_resp),
    .entry (buf_in),
    .pop   (buf_pop),
    .flush (redirect_valid),
    .head  (buf_head),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

  // In-flight addresses; stale entries leave through the normal pop on
  // their response, so this queue is only cleared by reset.
  fetch_fifo #(.DEPTH(FETCH_DEPTH)) u_pc_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .entry (pcq_in),
    .pop   (imem_resp_valid),
    .flush (1'b0),
    .head  (pcq_head),
    .count (pcq_count),
    .full  (pcq_full),
    .empty (pcq_empty)
  );

  assign unused_bits = ^{pcq_head.instr, pcq_count, pcq_full, pcq_empty,
                         buf_full, redirect_pc[1:0]};

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  logic        wrap_req_valid;
  logic [31:0] wrap_req_addr;
  logic        wrap_if_valid;
  logic [31:0] wrap_if_instr;
  logic [31:0] wrap_if_pc;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .FETCH_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc)
  );

  // Second instance only exercises the top-of-memory wrap from reset.
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .FETCH_DEPTH(D)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(wrap_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(wrap_req_addr),
    .imem_resp_valid(1'b0), .imem_resp_data(32'h0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .if_valid(wrap_if_valid), .if_ready(1'b0),
    .if_instr(wrap_if_instr), .if_pc(wrap_if_pc)
  );

  // Behavioural model: requests in flight (with a stale flag) and the
  // queue of instructions decode should see.
  typedef struct { logic [31:0] addr; int acc; bit drop; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  fl_t         fl_q[$];
  ent_t        fifo_q[$];
  logic [31:0] m_pc;
  bit          m_idle;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic        got_rv, got_if_valid, got2_rv;
  logic [31:0] got_addr, got_if_pc, got_if_instr, got2_addr;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    if (a == 32'h4) return 32'h0000_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    fl_q.delete();
    fifo_q.delete();
    m_pc   = 32'h0;
    m_idle = 1'b1;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    imem_resp_valid = 1'($urandom_range(1));
    imem_resp_data = $urandom();
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    repeat (n) begin
      @(negedge clk);
      imem_resp_valid = 1'($urandom_range(1));
      imem_resp_data = $urandom();
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    imem_resp_valid = 1'b0;
    model_reset();
  endtask

  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy,
                      input bit ifr, input int pct);
    bit   resp;
    bit   exp_rv;
    bit   accept;
    fl_t  f;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    if_ready       = ifr;
    resp = (fl_q.size() > 0) && (fl_q[0].acc < cyc) && (int'($urandom_range(99)) < pct);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? imem_word(fl_q[0].addr) : $urandom();
    #1;
    got_rv = imem_req_valid;   got_addr = imem_req_addr;
    got_if_valid = if_valid;   got_if_pc = if_pc;   got_if_instr = if_instr;
    got2_rv = wrap_req_valid;  got2_addr = wrap_req_addr;

    exp_rv = !m_idle && !redir && ((fl_q.size() + fifo_q.size()) < D);
    chk("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
    chk("if_valid", if_valid, fifo_q.size() != 0);
    if (fifo_q.size() != 0) begin
      chk("if_pc", if_pc, fifo_q[0].pc);
      chk("if_instr", if_instr, fifo_q[0].ins);
    end

    accept = exp_rv && rdy;
    if (resp) f = fl_q.pop_front();
    if (redir) begin
      fifo_q.delete();
      foreach (fl_q[i]) fl_q[i].drop = 1'b1;
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (fifo_q.size() != 0 && ifr) void'(fifo_q.pop_front());
      if (resp && !f.drop) fifo_q.push_back('{f.addr, imem_word(f.addr)});
      if (accept) begin
        fl_q.push_back('{m_pc, cyc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    m_idle = 1'b0;
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    model_reset();

    // Streaming from reset, plus the wrapping instance alongside.
    do_reset(2);
    step(0, 0, 1, 1, 100);
    chk("t1_idle_rv", got_rv, 1'b0);
    chk("wrap_idle_rv", got2_rv, 1'b0);
    step(0, 0, 1, 1, 100);
    chk("t1_addr0", got_addr, 32'h0);
    chk("wrap_addr0", got2_addr, 32'hFFFF_FFFC);
    step(0, 0, 1, 1, 100);
    chk("t1_addr1", got_addr, 32'h4);
    chk("t1_no_bypass", got_if_valid, 1'b0);
    chk("wrap_addr1", got2_addr, 32'h0000_0000);
    step(0, 0, 1, 1, 100);
    chk("t1_first_pc", got_if_pc, 32'h0);
    chk("t1_first_instr", got_if_instr, 32'h13);
    chk("wrap_no_credit", got2_rv, 1'b0);
    step(0, 0, 1, 1, 100);
    chk("t1_second_pc", got_if_pc, 32'h4);
    chk("t1_addr2", got_addr, 32'h8);

    // Decode stalled: credits run out after two requests.
    do_reset(1);
    step(0, 0, 1, 0, 100);
    step(0, 0, 1, 0, 100);
    step(0, 0, 1, 0, 100);
    step(0, 0, 1, 0, 100);
    chk("t2_stall_rv_d", got_rv, 1'b0);
    step(0, 0, 1, 0, 100);
    chk("t2_stall_rv_e", got_rv, 1'b0);
    chk("t2_head", got_if_instr, 32'h13);
    step(0, 0, 1, 1, 100);
    chk("t2_pop_instr", got_if_instr, 32'h13);
    step(0, 0, 1, 0, 100);
    chk("t2_refill_addr", got_addr, 32'h8);
    chk("t2_next_instr", got_if_instr, 32'h93);
    step(0, 0, 1, 0, 100);
    chk("t2_held_instr", got_if_instr, 32'h93);
    chk("t2_held_pc", got_if_pc, 32'h4);

    // Redirect with two requests in flight.
    do_reset(1);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    step(1, 32'h100, 1, 1, 0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(0, 0, 1, 1, 100);
      if (got_if_valid) begin
        seen = 1'b1;
        chk("t3_first_pc", got_if_pc, 32'h100);
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL t3_timeout: got no if_valid expected one within 10 cycles");
    end

    // Redirect coinciding with a response and a decode pop.
    do_reset(1);
    step(0, 0, 1, 0, 100);
    step(0, 0, 1, 0, 100);
    step(0, 0, 1, 0, 100);
    step(1, 32'h200, 1, 1, 100);
    step(0, 0, 1, 0, 0);
    chk("t4_empty", got_if_valid, 1'b0);
    chk("t4_target", got_addr, 32'h200);

    // Misaligned redirect target, taken in the idle cycle.
    do_reset(1);
    step(1, 32'h103, 1, 1, 100);
    step(0, 0, 1, 1, 100);
    chk("t5_aligned", got_addr, 32'h100);

    // Reset with work in flight and a full buffer.
    do_reset(1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 100);
    do_reset(3);
    step(0, 0, 1, 1, 100);
    chk("t6_idle_rv", got_rv, 1'b0);
    step(0, 0, 1, 1, 100);
    chk("t6_restart", got_addr, 32'h0);

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(399) == 0)
        do_reset(int'($urandom_range(3, 1)));
      else
        step($urandom_range(19) == 0,
             ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom(),
             $urandom_range(3) != 0, $urandom_range(2) != 0, 60);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the rv32i core, directly upstream of the decoder that consumes the OP_* opcode constants.
- Generates sequential PCs and issues word requests to instruction memory over a valid/ready request port.
- Tracks outstanding requests and buffers returned instructions with their PCs in a small FIFO.
- Presents buffered instructions to decode over a valid/ready handshake; branch/jump redirects flush stale work.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
FETCH_DEPTH, 2, FIFO entries and maximum requests in flight (power of two, >= 2).

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  imem accepts request this cycle
imem_req_addr  output  ADDR_WIDTH  word-aligned fetch address
imem_resp_valid  input  1  instruction returned (in order, >= 1 cycle after acceptance, never back-pressured)
imem_resp_data  input  DATA_WIDTH  returned instruction
redirect_valid  input  1  branch/jump redirect from execute
redirect_pc  input  ADDR_WIDTH  redirect target
if_valid  output  1  instruction available to decode
if_ready  input  1  decode accepts instruction
if_instr  output  DATA_WIDTH  instruction to decode
if_pc  output  ADDR_WIDTH  PC of if_instr

Behaviour:
- Reset (async, any cycle, including mid-flight):
  - pc_q=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0; state=IDLE.
  - Outputs during reset: imem_req_valid=0, if_valid=0, if_instr=0, if_pc=0.
  - Responses arriving during reset are ignored.
- FSM:
  - IDLE: one cycle after reset release, no request; ->RUN.
  - RUN: normal fetch; ->FLUSH on redirect while requests are outstanding.
  - FLUSH: drop_cnt>0; new requests allowed; ->RUN when drop_cnt reaches 0 with no new redirect.
- Credit rule: imem_req_valid = (state!=IDLE) && !redirect_valid && (outstanding + fifo_count < FETCH_DEPTH).
  - Dropped-but-pending responses count as outstanding.
- imem_req_addr = pc_q. On accept (valid&&ready): pc_q += 4, mod 2^32 (0xFFFF_FFFC -> 0x0); outstanding+1; pc_q is pushed into an internal PC queue.
- On imem_resp_valid:
  - If drop_cnt>0: discard the response, drop_cnt-1.
  - Otherwise push {head of PC queue, imem_resp_data} into the FIFO.
  - In both cases outstanding-1 and the PC queue pops.
- Accept and response in the same cycle: outstanding unchanged.
- Latency: request accepted in cycle t, response in t+1 -> if_valid in t+2. No bypass.
- Output: if_valid = FIFO non-empty; if_instr/if_pc = FIFO head; pop on if_valid&&if_ready.
- FIFO never overflows: the credit rule guarantees a slot for every non-dropped response. Overflow is an assertion failure.
- Redirect (priority over everything in that cycle):
  - FIFO flushed; a simultaneous decode pop is void.
  - pc_q = {redirect_pc[31:2],2'b00}; the low bits are ignored.
  - drop_cnt = outstanding minus any response arriving this cycle; that response is discarded.
  - No request is issued in the redirect cycle; the first request for the target issues the next cycle, if a credit is free.
  - Redirect while in FLUSH: drop_cnt recomputed the same way (prior drops included).
- if_instr/if_pc are held stable while if_valid && !if_ready.

Decomposition:
- Additions to _riscv_defines:
  - RESET_PC_DEFAULT constant.
  - FETCH_DEPTH_DEFAULT constant.
  - typedef enum fetch_state_t {FETCH_IDLE, FETCH_RUN, FETCH_FLUSH}.
  - typedef struct packed fetch_entry_t {pc[ADDR_WIDTH], instr[DATA_WIDTH]}.
- One sub-module, fetch_fifo: synchronous FIFO of fetch_entry_t, parameter DEPTH, with push, pop, flush, count, full and empty. Instantiated twice:
  - Entry buffer.
  - PC queue of in-flight addresses (flushed only by reset; dropped entries pop normally).

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle response, if_ready=1 -> requests 0x0,0x4,0x8; if_pc 0x0 appears 2 cycles after the first accept, then one instruction per cycle.
- if_ready=0, responses 0x13,0x93 -> exactly 2 requests (0x0,0x4), then imem_req_valid=0. if_ready=1 for one cycle -> if_instr=0x13 pops, and one new request for 0x8 issues.
- Two outstanding (0x0,0x4), redirect_pc=0x100 -> both responses dropped, next if_pc=0x100, no if_valid for 0x0 or 0x4.
- Redirect in the same cycle as imem_resp_valid and if_valid&&if_ready -> response discarded, FIFO empty next cycle, drop_cnt = remaining outstanding.
- RESET_PC=0xFFFF_FFFC -> addresses 0xFFFF_FFFC then 0x0000_0000. redirect_pc=0x103 -> fetch 0x100.
- rst asserted with 2 outstanding and FIFO full -> immediate if_valid=0 and imem_req_valid=0; after release, fetch restarts at RESET_PC and late responses during reset are ignored.
